mac_accumulator: RTL

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// Multiply-accumulate back end: sums signed product terms into a 40-bit accumulator
// and hands out one scaled 16-bit result per sum. Build with MAC_SAT_EN to clamp out-of-range results.
module mac_accumulator #(
  parameter int FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] prod_in,
  input  logic        prod_valid,
  input  logic        prod_last,
  output logic        prod_ready,
  output logic [15:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_cnt,
  output logic        res_ovf,
  output logic [1:0]  dbg_state
);

  // Handshakes: a term transfers on a cycle with prod_valid && prod_ready; a result
  // transfers on a cycle with res_valid && res_ready. Producers must hold data while waiting.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic signed [39:0] acc_q, acc_d;
  logic signed [39:0] prod_ext;
  logic signed [39:0] scaled;
  logic [7:0]         cnt_q, cnt_d;
  logic [15:0]        res_data_q, res_data_d;
  logic [7:0]         res_cnt_q, res_cnt_d;
  logic               res_ovf_q, res_ovf_d;
  logic               res_valid_q, res_valid_d;
  logic               accept;
  logic               load_res;
  logic               out_of_range;

  assign prod_ext   = {{8{prod_in[31]}}, prod_in};
  assign prod_ready = ~rst & (state_q != DONE);
  assign accept     = prod_valid & prod_ready;
  assign load_res   = accept & prod_last;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = prod_ext;
          cnt_d   = 8'd1;
          state_d = prod_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d   = acc_q + prod_ext;
          cnt_d   = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
          state_d = prod_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // The result is taken from the sum including the closing term, so scale acc_d.
  assign scaled       = acc_d >>> FRAC_BITS;
  assign out_of_range = ~((&scaled[39:15]) | ~(|scaled[39:15]));

  always_comb begin
    res_data_d  = res_data_q;
    res_cnt_d   = res_cnt_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;
    if (load_res) begin
      res_valid_d = 1'b1;
      res_cnt_d   = cnt_d;
      res_ovf_d   = out_of_range;
`ifdef MAC_SAT_EN
      if (out_of_range) begin
        res_data_d = scaled[39] ? 16'h8000 : 16'h7FFF;
      end else begin
        res_data_d = scaled[15:0];
      end
`else
      res_data_d = scaled[15:0];
`endif
    end else if (state_q == DONE && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_cnt_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_cnt_q   <= res_cnt_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_cnt   = res_cnt_q;
  assign res_ovf   = res_ovf_q;
  assign res_valid = res_valid_q;
  assign dbg_state = state_q;

endmodule
